// File: rtl/od_arb_tx.sv
// Bit-serial open-drain transmitter with wired-AND bitwise arbitration.
// Drives an external open-drain buffer and reads the resolved line back.
module od_arb_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int BIT_CYCLES   = 16,
    parameter int SAMPLE_POINT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  bus_in,
    output logic                  od_enable,
    output logic                  od_data,
    output logic                  busy,
    output logic                  done,
    output logic                  arb_lost,
    output logic                  frame_err,
    output logic [DATA_WIDTH-1:0] rx_data
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] BC_SAMP  = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0] IDLE_MAX = CW'(BIT_CYCLES);
    localparam logic [IW-1:0] IDX_TOP  = IW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                  s1;
    logic                  s2;
    logic                  bus_s;
    logic [CW-1:0]         idle_cnt;
    logic                  bus_idle;

    logic [2:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         bit_nx;
    logic [IW-1:0]         data_idx;
    logic [DATA_WIDTH-1:0] txr;
    logic                  lost;
    logic                  fin;

    logic                  bit_end;
    logic                  samp;
    logic                  cur_bit;
    logic                  accept;
    logic                  lose;
    logic                  drive;

    // Synchroniser idles high so a reset never looks like bus activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= bus_in;
            s2 <= s1;
        end
    end

    assign bus_s = s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!bus_s) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign bus_idle = (idle_cnt == IDLE_MAX);

    assign bit_end = (bit_cnt == BC_LAST);
    assign samp    = (bit_cnt == BC_SAMP);
    assign bit_nx  = bit_end ? '0 : bit_cnt + 1'b1;
    assign cur_bit = txr[data_idx];
    assign accept  = (state == S_IDLE) && !busy && start;

    // A recessive bit that reads back dominant means another master owns the bus
    assign lose = (state == S_DATA) && samp && !lost
                  && cur_bit && !bus_s;

    assign drive = (state == S_START)
                   || ((state == S_DATA) && !lost && !cur_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            data_idx <= '0;
            txr      <= '0;
            lost     <= 1'b0;
            fin      <= 1'b0;
        end else begin
            fin <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        txr      <= tx_data;
                        lost     <= 1'b0;
                        bit_cnt  <= '0;
                        data_idx <= IDX_TOP;
                        state    <= bus_idle ? S_START : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_idle) begin
                        bit_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    bit_cnt <= bit_nx;
                    if (bit_end) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    bit_cnt <= bit_nx;
                    if (lose) begin
                        lost <= 1'b1;
                    end
                    if (bit_end) begin
                        if (data_idx == '0) begin
                            state <= S_STOP;
                        end else begin
                            data_idx <= data_idx - 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    bit_cnt <= bit_nx;
                    if (bit_end) begin
                        fin   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs trail the sequencer by one cycle; busy spans the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            od_enable <= 1'b0;
            od_data   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            arb_lost  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= '0;
        end else begin
            od_enable <= drive;
            od_data   <= !drive;
            done      <= fin;
            if (accept) begin
                busy      <= 1'b1;
                arb_lost  <= 1'b0;
                frame_err <= 1'b0;
            end else if (fin) begin
                busy     <= 1'b0;
                arb_lost <= lost;
            end
            if ((state == S_DATA) && samp) begin
                rx_data <= {rx_data[DATA_WIDTH-2:0], bus_s};
            end
            if ((state == S_STOP) && samp && !bus_s) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_od_arb_tx.sv
// Directed bench for od_arb_tx: two masters share one pulled-up wire
// and the bench can hold the line low to emulate a foreign master.
module tb_od_arb_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold_low;
    logic       bus;

    logic       start_a;
    logic [7:0] tx_a;
    logic       en_a;
    logic       dat_a;
    logic       busy_a;
    logic       done_a;
    logic       lost_a;
    logic       ferr_a;
    logic [7:0] rx_a;

    logic       start_b;
    logic [7:0] tx_b;
    logic       en_b;
    logic       dat_b;
    logic       busy_b;
    logic       done_b;
    logic       lost_b;
    logic       ferr_b;
    logic [7:0] rx_b;

    int n_chk = 0;
    int n_fail = 0;

    logic en_h [0:299];
    logic bus_h [0:299];
    int   ndone;
    int   tdone;

    always #5 clk = ~clk;

    assign bus = ~((en_a & ~dat_a) | (en_b & ~dat_b) | hold_low);

    od_arb_tx u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .tx_data   (tx_a),
        .bus_in    (bus),
        .od_enable (en_a),
        .od_data   (dat_a),
        .busy      (busy_a),
        .done      (done_a),
        .arb_lost  (lost_a),
        .frame_err (ferr_a),
        .rx_data   (rx_a)
    );

    od_arb_tx u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .tx_data   (tx_b),
        .bus_in    (bus),
        .od_enable (en_b),
        .od_data   (dat_b),
        .busy      (busy_b),
        .done      (done_b),
        .arb_lost  (lost_b),
        .frame_err (ferr_b),
        .rx_data   (rx_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        tx_a    = d;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic run(input int n, input int poke,
                       input int h0, input int h1);
        ndone    = 0;
        tdone    = -1;
        en_h[0]  = en_a;
        bus_h[0] = bus;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == poke) begin
                start_a = 1'b1;
                tx_a    = 8'h0F;
            end
            if (k == poke + 1) start_a = 1'b0;
            if (k == h0) hold_low = 1'b1;
            if (k == h1) hold_low = 1'b0;
            en_h[k]  = en_a;
            bus_h[k] = bus;
            if (done_a) begin
                ndone++;
                if (tdone < 0) tdone = k;
            end
        end
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done_a && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] enb;
        logic [7:0] lnb;
        logic       en_any;
        int         cyc;
        int         d;

        rst_n    = 1'b0;
        hold_low = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        tx_a     = 8'h00;
        tx_b     = 8'h00;
        repeat (3) tick();
        check("rst_en", en_a, 0);
        check("rst_dat", dat_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_lost", lost_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_rx", rx_a, 0);
        rst_n = 1'b1;
        repeat (30) tick();

        // Single master 0xA5 on an idle line
        send_a(8'hA5);
        check("a5_busy_acc", busy_a, 1);
        run(170, -1, -1, -1);
        check("a5_en_acc", en_h[0], 0);
        check("a5_en_first", en_h[1], 1);
        check("a5_en_startbit", en_h[9], 1);
        for (int j = 0; j < 8; j++) begin
            enb[7-j] = en_h[25 + 16 * j];
            lnb[7-j] = bus_h[25 + 16 * j];
        end
        check("a5_en_bits", enb, 8'h5A);
        check("a5_line_bits", lnb, 8'hA5);
        check("a5_en_stop", en_h[153], 0);
        check("a5_done_time", tdone, 161);
        check("a5_done_cnt", ndone, 1);
        check("a5_rx", rx_a, 8'hA5);
        check("a5_lost", lost_a, 0);
        check("a5_ferr", ferr_a, 0);
        check("a5_busy_end", busy_a, 0);

        // Start re-pulsed mid-frame must be ignored
        repeat (30) tick();
        send_a(8'h96);
        run(200, 60, -1, -1);
        check("mid_done_cnt", ndone, 1);
        check("mid_done_time", tdone, 161);
        check("mid_rx", rx_a, 8'h96);

        // Asynchronous reset in the middle of a frame
        repeat (30) tick();
        send_a(8'h00);
        run(50, -1, -1, -1);
        check("rst50_en_pre", en_a, 1);
        check("rst50_busy_pre", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #2;
        check("rst50_en", en_a, 0);
        check("rst50_dat", dat_a, 1);
        check("rst50_busy", busy_a, 0);
        check("rst50_done", done_a, 0);
        check("rst50_lost", lost_a, 0);
        check("rst50_ferr", ferr_a, 0);
        check("rst50_rx", rx_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        send_a(8'h5A);
        wait_done(400, cyc);
        check("post_rst_time", cyc, 161);
        check("post_rst_rx", rx_a, 8'h5A);
        check("post_rst_ferr", ferr_a, 0);

        // Line held low across the stop bit
        repeat (30) tick();
        send_a(8'hFF);
        run(170, -1, 146, 156);
        check("stop_done_time", tdone, 161);
        check("stop_ferr", ferr_a, 1);
        check("stop_rx", rx_a, 8'hFF);
        check("stop_lost", lost_a, 0);

        // Start while the line is held low for 40 cycles
        repeat (30) tick();
        hold_low = 1'b1;
        repeat (5) tick();
        send_a(8'hC3);
        check("wait_busy_acc", busy_a, 1);
        check("wait_ferr_clr", ferr_a, 0);
        en_any = 1'b0;
        for (int k = 0; k < 34; k++) begin
            tick();
            en_any = en_any | en_a;
        end
        check("wait_en_held", en_any, 0);
        check("wait_busy_held", busy_a, 1);
        hold_low = 1'b0;
        d = 0;
        while (!en_a && d < 100) begin
            tick();
            d++;
        end
        check("wait_start_delay", (d >= 18 && d <= 20), 1);
        wait_done(400, cyc);
        check("wait_done_time", cyc, 160);
        check("wait_rx", rx_a, 8'hC3);

        // Two masters started together
        repeat (30) tick();
        tx_a    = 8'h3C;
        tx_b    = 8'h35;
        start_a = 1'b1;
        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        while (!done_a && !done_b && cyc < 400) begin
            tick();
            cyc++;
        end
        check("arb_done_time", cyc, 161);
        check("arb_done_a", done_a, 1);
        check("arb_done_b", done_b, 1);
        check("arb_rx_a", rx_a, 8'h35);
        check("arb_rx_b", rx_b, 8'h35);
        check("arb_lost_a", lost_a, 1);
        check("arb_lost_b", lost_b, 0);
        check("arb_ferr_a", ferr_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
